// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream, memory-write and status signals of the instruction-memory loader
interface imem_loader_if #(parameter int ADDR_W = 6);
  logic load_start;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_wdata;
  logic cpu_hold;
  logic load_done;
  logic load_err;
  logic [ADDR_W:0] words_loaded;
  modport master (
    output load_start, in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, words_loaded
  );
  modport slave (
    input  load_start, in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing little-endian words into instruction memory
module imem_loader #(parameter int ADDR_W = 6) (
  input logic clk,
  input logic rst,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;
  state_t state, state_n;
  logic [15:0] len, n_len;
  logic [7:0] csum;
  logic [1:0] lane;
  logic [ADDR_W:0] wcnt;
  logic acc, last;
  assign bus.in_ready = (state inside {LEN_LO, LEN_HI, DATA, CSUM}) && !bus.load_start;
  assign acc = bus.in_valid && bus.in_ready;
  assign n_len = {bus.in_data, len[7:0]};
  assign last = 16'(wcnt) + 16'd1 == len;
  assign bus.cpu_hold = state != DONE;
  assign bus.load_done = state == DONE;
  assign bus.load_err = state == ERR;
  assign bus.words_loaded = wcnt;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: restart wins over everything, otherwise advance on each accepted byte
  always_comb begin
    state_n = state;
    if (bus.load_start) state_n = LEN_LO;
    else if (acc)
      case (state)
        LEN_LO: state_n = LEN_HI;
        LEN_HI: state_n = {1'b0, n_len} > CAP ? ERR : n_len == 16'd0 ? CSUM : DATA;
        DATA: state_n = lane == 2'd3 && last ? CSUM : DATA;
        CSUM: state_n = bus.in_data == csum ? DONE : ERR;
        default: state_n = state;
      endcase
  end
  // length capture, lane assembly, running xor and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      len <= '0;
      csum <= '0;
      lane <= '0;
      wcnt <= '0;
      bus.im_we <= 1'b0;
      bus.im_addr <= '0;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      if (bus.load_start) begin
        lane <= '0;
        wcnt <= '0;
        csum <= '0;
      end else if (acc) begin
        if (state == LEN_LO) len[7:0] <= bus.in_data;
        if (state == LEN_HI) len[15:8] <= bus.in_data;
        if (state == DATA) begin
          bus.im_wdata[{lane, 3'b000} +: 8] <= bus.in_data;
          csum <= csum ^ bus.in_data;
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            bus.im_we <= 1'b1;
            bus.im_addr <= wcnt[ADDR_W-1:0];
            wcnt <= wcnt + (ADDR_W+1)'(1);
          end
        end
      end
    end
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream instruction-memory loader for the single-cycle LEGv8 core. It receives a framed program image over a valid/ready byte interface: a length, the instruction bytes, then a checksum. It assembles little-endian 32-bit instructions and writes them into instruction memory at consecutive word addresses. The CPU is held in reset until a complete, checksum-verified image is written; the core itself only reads that memory.

## Interface
Parameters:
- ADDR_W, 6: instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse that begins or restarts a load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts the byte this cycle.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  word address for the write.
- im_wdata  out  32  instruction word for the write.
- cpu_hold  out  1  drives the core's rst; high holds the CPU in reset.
- load_done  out  1  level; image loaded and checksum matched.
- load_err  out  1  level; oversize length or checksum mismatch.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N data bytes (each word LSB first), then CSUM = XOR of all 4N data bytes.
- States:
  - IDLE: after reset. Stays here until load_start.
  - LEN_LO: receives the low length byte, then goes to LEN_HI.
  - LEN_HI: receives the high length byte. If N > 2^ADDR_W, go to ERR. If N = 0, go to CSUM. Otherwise go to DATA.
  - DATA: receives data bytes. After the 4th byte of word N-1, go to CSUM.
  - CSUM: receives the checksum byte. Go to DONE if it matches, ERR if not.
  - DONE and ERR: terminal until load_start.
- A byte is accepted when in_valid && in_ready.
  - in_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM, and only while load_start = 0.
  - in_ready = 0 in IDLE, DONE and ERR.
- A 2-bit byte-lane counter fills im_wdata[8k+7:8k] for lane k. The running XOR and the word counter are cleared on entry to LEN_LO.
- Write: the cycle after the lane-3 byte is accepted, im_we = 1 for exactly one cycle. im_addr holds the word index (0,1,2,…), im_wdata holds the assembled word, and words_loaded increments in that same cycle.
- load_start in any state (including mid-load, DONE or ERR):
  - go to LEN_LO; clear the lane counter, word counter, XOR and the done/err flags;
  - set cpu_hold = 1;
  - a byte presented in that cycle is not accepted;
  - an im_we already registered for that cycle still completes.
- cpu_hold is 1 in every state except DONE. In ERR the CPU stays held.
- in_valid gaps of any length are legal; all state is held while no byte is accepted.

## Timing
- Reset values:
  - state IDLE;
  - in_ready 0, im_we 0, im_addr 0, im_wdata 0;
  - cpu_hold 1, load_done 0, load_err 0, words_loaded 0.
- rst asserted mid-load aborts immediately on the next edge to the reset values. Writes already completed are not undone.
- Write latency: 1 cycle from acceptance of the 4th byte to the im_we edge.
- The checksum byte is accepted at cycle T at the earliest (one cycle after the last data byte). At T+1:
  - state is DONE or ERR;
  - load_done or load_err rises;
  - cpu_hold falls (DONE only).
- The last im_we always precedes cpu_hold release by at least 1 cycle.
- Oversize length: load_err = 1 the cycle after LEN_HI is accepted. No im_we is ever issued for that frame.
- load_done and load_err are never 1 simultaneously.

## Test plan
- Two-word load: load_start, then 02 00 21 04 00 91 C0 03 1F D6 BE, in_valid held high.
  - im_we at addr 0 with 0x91000421, then at addr 1 with 0xD61F03C0.
  - load_done = 1, cpu_hold = 0, words_loaded = 2.
- Bad checksum: same frame with CSUM = BF.
  - Both writes still occur.
  - load_err = 1, cpu_hold stays 1, load_done = 0.
- Oversize length with ADDR_W = 6: frame 41 00.
  - load_err the next cycle, no im_we, in_ready = 0.
  - A following load_start with a valid frame recovers to DONE.
- Zero length: frame 00 00 00.
  - No im_we, load_done = 1, words_loaded = 0.
- Gappy stream plus restart:
  - random in_valid gaps on the two-word frame give the same writes and result;
  - load_start after byte 5 restarts the load, and the next full frame writes from addr 0;
  - a byte coincident with load_start is not accepted.
- Reset mid-DATA: rst asserted after 6 bytes.
  - All outputs return to reset values and state is IDLE; in_ready = 0 until load_start.
